// File: rtl/id_sequencer.sv
// id_sequencer: ID-stage register, opcode/immediate-select decode,
// load-use hazard detection and the ID/EX control register.
//
// Ports
//   CLK, RESET          rising-edge clock, async active-high reset
//   IF_INSTR, IF_VALID  fetched instruction and its valid flag
//   ID_READY            ID register accepts IF_INSTR this cycle
//   EX_STALL            downstream hold of the ID/EX register
//   FLUSH               taken branch/jump, kills ID and ID/EX
//   IMM_IN, IMM_SEL     ID instr[31:7] and immediate-select code
//   EX_VALID, EX_RD     ID/EX slot valid and its rd
//   EX_IS_LOAD          ID/EX instruction is a load
//   EX_IMM_USED         ID/EX instruction consumes an immediate
//   ILLEGAL             valid ID instruction has unsupported opcode
//   HAZARD              load-use stall active this cycle
//
// Build option: define LOAD_USE_STALL_EN to enable load-use stalls;
// otherwise HAZARD is tied low and no bubbles are inserted.
// Immediate-select codes fall back to local values when the shared
// encodings header has not already defined them.

`ifndef I_SIGNED_TYPE
`define I_SIGNED_TYPE 3'd0
`endif
`ifndef I_SHIFT_TYPE
`define I_SHIFT_TYPE 3'd1
`endif
`ifndef I_UNSIGNED_TYPE
`define I_UNSIGNED_TYPE 3'd2
`endif
`ifndef S_TYPE
`define S_TYPE 3'd3
`endif
`ifndef B_TYPE
`define B_TYPE 3'd4
`endif
`ifndef U_TYPE
`define U_TYPE 3'd5
`endif
`ifndef J_TYPE
`define J_TYPE 3'd6
`endif

module id_sequencer #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] IF_INSTR,
   input  logic        IF_VALID,
   output logic        ID_READY,
   input  logic        EX_STALL,
   input  logic        FLUSH,
   output logic [24:0] IMM_IN,
   output logic [2:0]  IMM_SEL,
   output logic        EX_VALID,
   output logic [4:0]  EX_RD,
   output logic        EX_IS_LOAD,
   output logic        EX_IMM_USED,
   output logic        ILLEGAL,
   output logic        HAZARD
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   logic [31:0] id_instr;
   logic        id_valid;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic        imm_used;
   logic        is_load;
   logic        known;

   assign opcode = id_instr[6:0];
   assign funct3 = id_instr[14:12];
   assign rd     = id_instr[11:7];

   always_comb begin
      IMM_SEL  = `I_SIGNED_TYPE;
      imm_used = 1'b1;
      is_load  = 1'b0;
      known    = 1'b1;
      case (opcode)
         OP_LUI, OP_AUIPC: IMM_SEL = `U_TYPE;
         OP_JAL:           IMM_SEL = `J_TYPE;
         OP_BRANCH:        IMM_SEL = `B_TYPE;
         OP_STORE:         IMM_SEL = `S_TYPE;
         OP_JALR:          IMM_SEL = `I_SIGNED_TYPE;
         OP_LOAD:          is_load = 1'b1;
         OP_IMM: begin
            case (funct3)
               3'b001, 3'b101: IMM_SEL = `I_SHIFT_TYPE;
               3'b011:         IMM_SEL = `I_UNSIGNED_TYPE;
               default:        IMM_SEL = `I_SIGNED_TYPE;
            endcase
         end
         OP_OP:            imm_used = 1'b0;
         default: begin
            imm_used = 1'b0;
            known    = 1'b0;
         end
      endcase
   end

   assign IMM_IN   = id_instr[31:7];
   assign ILLEGAL  = id_valid && !known;
   assign ID_READY = !HAZARD && !EX_STALL;

`ifdef LOAD_USE_STALL_EN
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       rs1_used;
   logic       rs2_used;
   logic       rs1_hit;
   logic       rs2_hit;

   assign rs1 = id_instr[19:15];
   assign rs2 = id_instr[24:20];

   assign rs1_used = !(opcode == OP_LUI ||
                       opcode == OP_AUIPC ||
                       opcode == OP_JAL);
   assign rs2_used = opcode == OP_BRANCH ||
                     opcode == OP_STORE ||
                     opcode == OP_OP;

   assign rs1_hit = rs1_used && (rs1 == EX_RD);
   assign rs2_hit = rs2_used && (rs2 == EX_RD);

   assign HAZARD = id_valid && EX_VALID && EX_IS_LOAD &&
                   (EX_RD != 5'd0) && (rs1_hit || rs2_hit);
`else
   assign HAZARD = 1'b0;
`endif

   // ID register: an idle ready cycle drops the valid bit but keeps
   // the word, so IMM_IN still reflects the last fetched instruction.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         id_instr <= NOP_INSTR;
         id_valid <= 1'b0;
      end else if (FLUSH) begin
         id_instr <= NOP_INSTR;
         id_valid <= 1'b0;
      end else if (ID_READY) begin
         if (IF_VALID) id_instr <= IF_INSTR;
         id_valid <= IF_VALID;
      end
   end

   // ID/EX register: a hazard advances a bubble while ID holds.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         EX_VALID    <= 1'b0;
         EX_RD       <= 5'd0;
         EX_IS_LOAD  <= 1'b0;
         EX_IMM_USED <= 1'b0;
      end else if (FLUSH) begin
         EX_VALID    <= 1'b0;
         EX_RD       <= 5'd0;
         EX_IS_LOAD  <= 1'b0;
         EX_IMM_USED <= 1'b0;
      end else if (!EX_STALL) begin
         EX_VALID    <= id_valid && !HAZARD;
         EX_RD       <= rd;
         EX_IS_LOAD  <= is_load;
         EX_IMM_USED <= imm_used;
      end
   end

endmodule

// File: tb/tb_id_sequencer.sv
// tb_id_sequencer: randomized and directed stimulus for id_sequencer,
// checked by a queue-based scoreboard against a slot-level model.

module tb_id_sequencer;

   localparam logic [31:0] NOP = 32'h00000013;

   localparam logic [2:0] I_SIGNED_T   = 3'd0;
   localparam logic [2:0] I_SHIFT_T    = 3'd1;
   localparam logic [2:0] I_UNSIGNED_T = 3'd2;
   localparam logic [2:0] S_T          = 3'd3;
   localparam logic [2:0] B_T          = 3'd4;
   localparam logic [2:0] U_T          = 3'd5;
   localparam logic [2:0] J_T          = 3'd6;

`ifdef LOAD_USE_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic        CLK;
   logic        RESET;
   logic [31:0] IF_INSTR;
   logic        IF_VALID;
   logic        ID_READY;
   logic        EX_STALL;
   logic        FLUSH;
   logic [24:0] IMM_IN;
   logic [2:0]  IMM_SEL;
   logic        EX_VALID;
   logic [4:0]  EX_RD;
   logic        EX_IS_LOAD;
   logic        EX_IMM_USED;
   logic        ILLEGAL;
   logic        HAZARD;

   id_sequencer #(.NOP_INSTR(NOP)) dut (
      .CLK(CLK), .RESET(RESET),
      .IF_INSTR(IF_INSTR), .IF_VALID(IF_VALID),
      .ID_READY(ID_READY), .EX_STALL(EX_STALL),
      .FLUSH(FLUSH), .IMM_IN(IMM_IN), .IMM_SEL(IMM_SEL),
      .EX_VALID(EX_VALID), .EX_RD(EX_RD),
      .EX_IS_LOAD(EX_IS_LOAD), .EX_IMM_USED(EX_IMM_USED),
      .ILLEGAL(ILLEGAL), .HAZARD(HAZARD)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef enum int {
      F_U, F_J, F_B, F_S, F_LD, F_JR, F_ALU, F_R, F_BAD
   } fmt_e;

   typedef struct {
      logic        ready;
      logic        hz;
      logic        ill;
      logic        exv;
      logic [24:0] imm;
      logic [2:0]  sel;
      bit          chk_ex;
      logic [4:0]  rd;
      logic        ld;
      logic        iu;
      bit          d_rst;
      bit          d_sel_en;
      logic [2:0]  d_sel;
      bit          d_ill_en;
      logic        d_ill;
      bit          d_fl;
      bit          d_mark;
      bit          d_hz_en;
      int          d_hz;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int errors = 0;
   int hz_count = 0;
   int hz_mark = 0;

   function automatic fmt_e fmt_of(input logic [31:0] i);
      case (i[6:0])
         7'b0110111, 7'b0010111: return F_U;
         7'b1101111: return F_J;
         7'b1100011: return F_B;
         7'b0100011: return F_S;
         7'b0000011: return F_LD;
         7'b1100111: return F_JR;
         7'b0010011: return F_ALU;
         7'b0110011: return F_R;
         default:    return F_BAD;
      endcase
   endfunction

   function automatic logic [2:0] sel_of(input logic [31:0] i);
      logic [2:0] f3;
      f3 = i[14:12];
      case (fmt_of(i))
         F_U: return U_T;
         F_J: return J_T;
         F_B: return B_T;
         F_S: return S_T;
         F_ALU: begin
            if (f3 == 3'd1 || f3 == 3'd5) return I_SHIFT_T;
            if (f3 == 3'd3) return I_UNSIGNED_T;
            return I_SIGNED_T;
         end
         default: return I_SIGNED_T;
      endcase
   endfunction

   function automatic logic imm_used_of(input logic [31:0] i);
      fmt_e f;
      f = fmt_of(i);
      return !(f == F_R || f == F_BAD);
   endfunction

   // Model: the instruction word sitting in each slot.
   logic [31:0] m_id;
   logic        m_idv;
   logic [31:0] m_ex;
   logic        m_exv;
   logic        m_ex_zero;

   task automatic model_reset();
      m_id      = NOP;
      m_idv     = 1'b0;
      m_ex      = 32'd0;
      m_exv     = 1'b0;
      m_ex_zero = 1'b1;
   endtask

   function automatic logic hz_now();
      fmt_e        fi;
      logic [4:0]  dst;
      logic        u1;
      logic        u2;
      fi  = fmt_of(m_id);
      dst = m_ex[11:7];
      u1  = !(fi == F_U || fi == F_J);
      u2  = fi == F_B || fi == F_S || fi == F_R;
      return STALL_EN && m_idv && m_exv &&
             fmt_of(m_ex) == F_LD && dst != 5'd0 &&
             ((u1 && m_id[19:15] == dst) ||
              (u2 && m_id[24:20] == dst));
   endfunction

   // Directed checks attached to the next pushed entry.
   bit         p_rst;
   bit         p_sel_en;
   logic [2:0] p_sel;
   bit         p_ill_en;
   logic       p_ill;
   bit         p_fl;
   bit         p_mark;
   bit         p_hz_en;
   int         p_hz;
   bit         acc;

   task automatic clear_pend();
      p_rst = 0; p_sel_en = 0; p_sel = 3'd0;
      p_ill_en = 0; p_ill = 1'b0; p_fl = 0;
      p_mark = 0; p_hz_en = 0; p_hz = 0;
   endtask

   task automatic cycle(input logic [31:0] ins, input logic v,
                        input logic st, input logic fl,
                        input logic rs);
      exp_t e;
      @(posedge CLK);
      #1;
      IF_INSTR = ins;
      IF_VALID = v;
      EX_STALL = st;
      FLUSH    = fl;
      RESET    = rs;
      if (rs) model_reset();
      e.hz     = hz_now();
      e.ready  = !e.hz && !st;
      e.ill    = m_idv && fmt_of(m_id) == F_BAD;
      e.exv    = m_exv;
      e.imm    = m_id[31:7];
      e.sel    = sel_of(m_id);
      e.chk_ex = m_ex_zero || m_exv;
      e.rd     = m_ex_zero ? 5'd0 : m_ex[11:7];
      e.ld     = !m_ex_zero && fmt_of(m_ex) == F_LD;
      e.iu     = !m_ex_zero && imm_used_of(m_ex);
      e.d_rst = p_rst; e.d_sel_en = p_sel_en; e.d_sel = p_sel;
      e.d_ill_en = p_ill_en; e.d_ill = p_ill; e.d_fl = p_fl;
      e.d_mark = p_mark; e.d_hz_en = p_hz_en; e.d_hz = p_hz;
      q.push_back(e);
      clear_pend();
      acc = !rs && !fl && e.ready && v;
      if (!rs) begin
         if (fl) begin
            m_id      = NOP;
            m_idv     = 1'b0;
            m_exv     = 1'b0;
            m_ex_zero = 1'b0;
         end else begin
            if (!st) begin
               m_ex      = m_id;
               m_exv     = m_idv && !e.hz;
               m_ex_zero = 1'b0;
            end
            if (e.ready) begin
               if (v) m_id = ins;
               m_idv = v;
            end
         end
      end
   endtask

   task automatic feed(input logic [31:0] ins);
      acc = 0;
      for (int n = 0; n < 6 && !acc; n++) cycle(ins, 1, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(NOP, 0, 0, 0, 0);
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 3))
         0: return 5'd0;
         1: return 5'd1;
         2: return 5'd2;
         default: return 5'd5;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] op;
      logic [6:0] f7;
      logic [2:0] f3;
      case ($urandom_range(0, 12))
         0: op = 7'b0110111;
         1: op = 7'b0010111;
         2: op = 7'b1101111;
         3: op = 7'b1100111;
         4: op = 7'b1100011;
         5, 6, 7: op = 7'b0000011;
         8: op = 7'b0100011;
         9: op = 7'b0010011;
         10: op = 7'b0110011;
         11: op = 7'b0001011;
         default: op = 7'($urandom);
      endcase
      f7 = 7'($urandom);
      f3 = 3'($urandom);
      return {f7, pick_reg(), pick_reg(), f3, pick_reg(), op};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h",
                  name, $time, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.d_mark) hz_mark = hz_count;
         if (HAZARD === 1'b1) hz_count++;
         chk("id_ready", 32'(ID_READY), 32'(e.ready));
         chk("hazard", 32'(HAZARD), 32'(e.hz));
         chk("illegal", 32'(ILLEGAL), 32'(e.ill));
         chk("ex_valid", 32'(EX_VALID), 32'(e.exv));
         chk("imm_in", 32'(IMM_IN), 32'(e.imm));
         chk("imm_sel", 32'(IMM_SEL), 32'(e.sel));
         if (e.chk_ex) begin
            chk("ex_rd", 32'(EX_RD), 32'(e.rd));
            chk("ex_is_load", 32'(EX_IS_LOAD), 32'(e.ld));
            chk("ex_imm_used", 32'(EX_IMM_USED), 32'(e.iu));
         end
         if (e.d_rst) begin
            chk("rst_ex_valid", 32'(EX_VALID), 32'd0);
            chk("rst_imm_sel", 32'(IMM_SEL), 32'(I_SIGNED_T));
            chk("rst_imm_in", 32'(IMM_IN), 32'd0);
            chk("rst_id_ready", 32'(ID_READY), 32'd1);
            chk("rst_hazard", 32'(HAZARD), 32'd0);
         end
         if (e.d_sel_en)
            chk("sweep_imm_sel", 32'(IMM_SEL), 32'(e.d_sel));
         if (e.d_ill_en)
            chk("illegal_dir", 32'(ILLEGAL), 32'(e.d_ill));
         if (e.d_fl) begin
            chk("flush_ex_valid", 32'(EX_VALID), 32'd0);
            chk("flush_hazard", 32'(HAZARD), 32'd0);
            chk("flush_imm_in", 32'(IMM_IN), 32'(NOP[31:7]));
         end
         if (e.d_hz_en)
            chk("hazard_cycles", 32'(hz_count - hz_mark),
                32'(e.d_hz));
      end
   end

   logic [31:0] sweep[6];
   logic [2:0]  sweep_sel[6];

   localparam logic [31:0] LW5   = 32'h0000A283;
   localparam logic [31:0] ADD65 = 32'h00228333;
   localparam logic [31:0] LW0   = 32'h0000A003;
   localparam logic [31:0] ADD60 = 32'h00200333;

   initial begin
      RESET = 1'b1; IF_INSTR = NOP; IF_VALID = 1'b0;
      EX_STALL = 1'b0; FLUSH = 1'b0;
      model_reset();
      clear_pend();
      sweep[0] = 32'h00000537; sweep_sel[0] = U_T;
      sweep[1] = 32'h0000006F; sweep_sel[1] = J_T;
      sweep[2] = 32'h0020A023; sweep_sel[2] = S_T;
      sweep[3] = 32'h00008063; sweep_sel[3] = B_T;
      sweep[4] = 32'h0050D093; sweep_sel[4] = I_SHIFT_T;
      sweep[5] = 32'h0050B093; sweep_sel[5] = I_UNSIGNED_T;

      p_rst = 1;
      cycle(NOP, 0, 0, 0, 1);
      cycle(NOP, 0, 0, 0, 1);
      idle(2);

      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            p_sel_en = 1; p_sel = sweep_sel[i-1];
         end
         cycle(sweep[i], 1, 0, 0, 0);
      end
      p_sel_en = 1; p_sel = sweep_sel[5];
      cycle(NOP, 0, 0, 0, 0);
      idle(2);

      p_mark = 1;
      cycle(NOP, 0, 0, 0, 0);
      feed(LW5);
      feed(ADD65);
      idle(3);
      p_hz_en = 1; p_hz = STALL_EN ? 1 : 0;
      cycle(NOP, 0, 0, 0, 0);

      p_mark = 1;
      cycle(NOP, 0, 0, 0, 0);
      feed(LW0);
      feed(ADD60);
      idle(3);
      p_hz_en = 1; p_hz = 0;
      cycle(NOP, 0, 0, 0, 0);

      feed(LW5);
      feed(ADD65);
      cycle(32'h00000537, 1, 0, 1, 0);
      p_fl = 1;
      p_ill_en = 1; p_ill = 1'b0;
      cycle(NOP, 0, 0, 0, 0);
      idle(1);

      feed(32'h00100093);
      feed(32'h00200113);
      feed(32'h00300193);
      cycle(32'h00400213, 1, 1, 0, 0);
      cycle(32'h00400213, 1, 1, 0, 0);
      cycle(32'h00400213, 1, 1, 0, 0);
      feed(32'h00400213);
      idle(3);

      feed(32'h0000000B);
      p_ill_en = 1; p_ill = 1'b1;
      cycle(NOP, 0, 1, 0, 0);
      p_ill_en = 1; p_ill = 1'b1;
      cycle(NOP, 0, 1, 0, 0);
      p_ill_en = 1; p_ill = 1'b1;
      cycle(LW5, 1, 0, 1, 0);
      p_ill_en = 1; p_ill = 1'b0;
      cycle(NOP, 0, 0, 0, 0);

      feed(LW5);
      feed(ADD65);
      p_rst = 1;
      cycle(ADD65, 1, 0, 0, 1);
      cycle(ADD65, 1, 1, 1, 0);
      feed(ADD65);
      idle(3);

      for (int c = 0; c < 500; c++) begin
         logic rs;
         rs = ($urandom_range(0, 96) == 0);
         p_rst = rs;
         cycle(rand_instr(), $urandom_range(0, 3) != 0,
               rs ? 1'b0 : ($urandom_range(0, 4) == 0),
               $urandom_range(0, 19) == 0, rs);
      end
      idle(3);
      @(negedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
